// File: rtl/alu_acc_seq.sv
// alu_acc_seq: sequencer around an external combinational ALU with a WIDTH-bit accumulator.
// A command is accepted in IDLE and applied in EXEC. The result is then held in RESP
// until the consumer accepts it.
//
// Ports:
//   clk, rst          - clock (rising edge) and asynchronous active-high reset
//   in_valid/in_ready - command handshake; in_cmd[3] = LOAD, in_cmd[2:0] = ALU select
//   in_operand        - signed operand B, captured on handshake
//   alu_a/alu_b/alu_sel - buses to the external ALU (A = acc, B = captured operand)
//   alu_res/alu_zero/alu_neg - combinational ALU result and flags
//   out_valid/out_ready - result handshake; out_data mirrors the accumulator
//   out_zero/out_neg  - registered flags of the last executed command
//   op_count          - completed-command count, wraps at 255
module alu_acc_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [3:0]              in_cmd,
  input  logic signed [WIDTH-1:0] in_operand,
  output logic signed [WIDTH-1:0] alu_a,
  output logic signed [WIDTH-1:0] alu_b,
  output logic [2:0]              alu_sel,
  input  logic signed [WIDTH-1:0] alu_res,
  input  logic                    alu_zero,
  input  logic                    alu_neg,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data,
  output logic                    out_zero,
  output logic                    out_neg,
  output logic [7:0]              op_count
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [3:0]       cmd_q, cmd_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic [7:0]       cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      opnd_q  <= '0;
      cmd_q   <= '0;
      zero_q  <= 1'b1;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      cmd_q   <= cmd_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    cmd_d   = cmd_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          opnd_d  = in_operand;
          cmd_d   = in_cmd;
          state_d = StExec;
        end
      end
      StExec: begin
        if (cmd_q[3]) begin
          // LOAD bypasses the ALU; flags are derived from the operand itself.
          acc_d  = opnd_q;
          zero_d = (opnd_q == '0);
          neg_d  = opnd_q[WIDTH-1];
        end else begin
          acc_d  = alu_res;
          zero_d = alu_zero;
          neg_d  = alu_neg;
        end
        state_d = StExec == state_q ? StResp : state_q;
      end
      StResp: begin
        if (out_ready) begin
          state_d = StIdle;
          cnt_d   = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StResp);
  assign alu_a     = acc_q;
  assign alu_b     = opnd_q;
  // The select is only presented while the ALU result is actually consumed.
  assign alu_sel   = (state_q == StExec) ? cmd_q[2:0] : 3'b000;
  assign out_data  = acc_q;
  assign out_zero  = zero_q;
  assign out_neg   = neg_q;
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_alu_acc_seq.sv
module tb_alu_acc_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_cmd;
  logic [7:0] in_operand;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_sel;
  logic [7:0] alu_res;
  logic       alu_zero;
  logic       alu_neg;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_zero;
  logic       out_neg;
  logic [7:0] op_count;

  alu_acc_seq #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_cmd     (in_cmd),
    .in_operand (in_operand),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_res    (alu_res),
    .alu_zero   (alu_zero),
    .alu_neg    (alu_neg),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_zero   (out_zero),
    .out_neg    (out_neg),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [2:0] sel, input logic [7:0] a,
                                       input logic [7:0] b);
    logic [7:0] r;
    case (sel)
      3'd1:    r = a + b;
      3'd2:    r = a - b;
      3'd3:    r = a * b;
      3'd4:    r = $signed(a) / 8'sd2;
      default: r = a;
    endcase
    return r;
  endfunction

  // External ALU model.
  always_comb begin
    alu_res  = alu_f(alu_sel, alu_a, alu_b);
    alu_zero = (alu_res == 8'd0);
    alu_neg  = alu_res[7];
  end

  typedef struct packed {
    logic [7:0] data;
    logic       zero;
    logic       neg;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb_q[$];
  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] m_acc;
  logic [7:0] m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] cmd, input logic [7:0] opnd);
    exp_t e;
    m_acc  = cmd[3] ? opnd : alu_f(cmd[2:0], m_acc, opnd);
    m_cnt  = m_cnt + 8'd1;
    e.data = m_acc;
    e.zero = (m_acc == 8'd0);
    e.neg  = m_acc[7];
    e.cnt  = m_cnt;
    sb_q.push_back(e);
  endtask

  task automatic send(input logic [3:0] cmd, input logic [7:0] opnd);
    int t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("send_ready", in_ready, 1);
    if (!in_ready) return;
    in_valid   = 1'b1;
    in_cmd     = cmd;
    in_operand = opnd;
    push(cmd, opnd);
    @(negedge clk);
    in_valid = 1'b0;
    check("exec_in_ready", in_ready, 0);
    check("exec_out_valid", out_valid, 0);
  endtask

  task automatic recv(input int hold, output logic [7:0] data);
    int   t = 0;
    exp_t e;
    data = 8'd0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("out_valid_seen", out_valid, 1);
    if (!out_valid) return;
    check("sb_nonempty", (sb_q.size() > 0), 1);
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    check("data", out_data, e.data);
    check("zero", out_zero, e.zero);
    check("neg", out_neg, e.neg);
    data = out_data;
    for (int i = 0; i < hold; i++) begin
      in_valid   = 1'b1;
      in_cmd     = 4'h8;
      in_operand = 8'h77;
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, e.data);
      check("hold_zero", out_zero, e.zero);
      check("hold_neg", out_neg, e.neg);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_valid_low", out_valid, 0);
    check("op_count", op_count, e.cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
    int         sent;
    int         got;
    logic       prev_v;
    exp_t       e;

    rst        = 1'b1;
    in_valid   = 1'b0;
    in_cmd     = 4'h0;
    in_operand = 8'h00;
    out_ready  = 1'b0;
    m_acc      = 8'd0;
    m_cnt      = 8'd0;
    #12;
    check("rst_out_data", out_data, 8'h00);
    check("rst_out_zero", out_zero, 1);
    check("rst_out_neg", out_neg, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_op_count", op_count, 8'h00);
    check("rst_alu_sel", alu_sel, 3'b000);
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-EXEC: asynchronous clear, command discarded.
    send(4'h8, 8'h33);
    #2 rst = 1'b1;
    #1;
    check("arst_out_data", out_data, 8'h00);
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_op_count", op_count, 8'h00);
    #1 rst = 1'b0;
    sb_q.delete();
    m_acc = 8'd0;
    m_cnt = 8'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("arst_no_pulse", out_valid, 0);
    end
    check("arst_cnt_kept", op_count, 8'h00);

    // LOAD 5, ADD 3.
    send(4'h8, 8'd5);
    recv(0, d);
    check("load5", d, 8'd5);
    send(4'h1, 8'd3);
    recv(0, d);
    check("add3", d, 8'd8);
    check("add3_cnt", op_count, 8'd2);

    // SUB 10 -> -2.
    send(4'h2, 8'd10);
    recv(0, d);
    check("sub10", d, 8'hFE);
    check("sub10_neg", out_neg, 1);
    check("sub10_zero", out_zero, 0);

    // LOAD 16, MUL 16 wraps to zero.
    send(4'h8, 8'd16);
    recv(0, d);
    send(4'h3, 8'd16);
    recv(0, d);
    check("mul_wrap", d, 8'h00);
    check("mul_zero", out_zero, 1);

    // LOAD -7, DIV2 -> -3.
    send(4'h8, 8'hF9);
    recv(0, d);
    send(4'h4, 8'h00);
    recv(0, d);
    check("div2", d, 8'hFD);

    // Backpressure: RESP held 5 cycles, in_valid ignored.
    send(4'h1, 8'd1);
    recv(5, d);
    check("hold_result", d, 8'hFE);
    @(negedge clk);
    check("hold_no_extra", out_valid, 0);
    check("hold_acc_kept", out_data, 8'hFE);

    // Clear count, then 256 back-to-back commands.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    m_acc     = 8'd0;
    m_cnt     = 8'd0;
    out_ready = 1'b1;
    sent      = 0;
    got       = 0;
    prev_v    = 1'b0;
    for (int cyc = 0; cyc < 1200 && got < 256; cyc++) begin
      if (out_valid) begin
        check("b2b_pulse_width", prev_v, 0);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check("b2b_data", out_data, e.data);
        end
        got++;
      end
      prev_v = out_valid;
      if (in_ready && sent < 256) begin
        in_valid   = 1'b1;
        in_cmd     = sent[0] ? 4'h1 : 4'h8;
        in_operand = sent[7:0];
        push(in_cmd, in_operand);
        sent++;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    check("b2b_count", got, 256);
    check("b2b_wrap", op_count, 8'h00);
    @(negedge clk);
    check("b2b_idle", out_valid, 0);
    out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
